csi2_packet_parser: RTL and testbench

- Sits directly downstream of the 2-lane byte aligner and consumes its 16-bit word stream.
- Parses the CSI-2 packet header: DI, WC and ECC.
- Decodes short packets (FS/FE/LS/LE) into strobes.
- Streams long-packet payload with byte enables, consumes the CRC trailer, and returns `packet_done` to the aligner so the aligner drops `word_vld`.
- Single clock domain; the output feeds the pixel unpacker.

---
 rtl/csi2_pkg.sv | 31 +++
 rtl/csi2_crc16.sv | 33 +++
 rtl/csi2_packet_parser.sv | 199 +++++++++++++++++++
 tb/tb_csi2_packet_parser.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// Shared constants, FSM encoding and the CRC-16 byte step for the CSI-2 packet parser.
// The CRC engine is only built when CSI2_CRC_CHECK_EN is defined.
package csi2_pkg;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;
  localparam logic [5:0] DT_LE = 6'h03;

  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    HDR1,
    PAYLOAD,
    CRC,
    DONE
  } state_t;

  // Reflected CRC-16 advanced by one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Running CRC-16 over up to two payload bytes per cycle; low byte is the earlier byte.
// Instantiated by csi2_packet_parser only under CSI2_CRC_CHECK_EN.
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_clear,
  input  logic [15:0] i_data,
  input  logic [1:0]  i_be,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic [15:0] w_lo;
  logic [15:0] w_hi;

  always_comb begin
    w_lo = i_be[0] ? crc16_byte(r_crc, i_data[7:0]) : r_crc;
    w_hi = i_be[1] ? crc16_byte(w_lo, i_data[15:8]) : w_lo;
  end

  always_ff @(posedge clk) begin
    if (!resetn || i_clear) begin
      r_crc <= CRC_SEED;
    end else begin
      r_crc <= w_hi;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser: header decode, short-packet strobes, payload streaming and trailer consumption.
// Optional CRC-16 trailer check is enabled with `define CSI2_CRC_CHECK_EN.
module csi2_packet_parser
  import csi2_pkg::*;
#(
  parameter logic [15:0] MAX_WC       = 16'd8192,
  parameter logic [5:0]  DT_SHORT_MAX = 6'h0F
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] word_data,
  input  logic        word_vld,
  input  logic        invalid_start,
  output logic        packet_done,
  output logic        hdr_vld,
  output logic [1:0]  vc,
  output logic [5:0]  dt,
  output logic [15:0] wc,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [15:0] pix_data,
  output logic [1:0]  pix_be,
  output logic        pix_vld,
  output logic        pix_last,
  output logic        err_wc,
  output logic        err_sync,
  output logic        err_trunc,
  output logic        err_crc
);

  state_t      r_state;
  logic [15:0] r_word0;
  logic [15:0] r_rem;
  logic [7:0]  w_di;
  logic [15:0] w_wc;

  assign w_di = r_word0[7:0];
  assign w_wc = {word_data[7:0], r_word0[15:8]};

`ifdef CSI2_CRC_CHECK_EN
  logic        r_odd;
  logic [7:0]  r_crcLsb;
  logic [15:0] w_rxCrc;
  logic [15:0] w_crc;
  logic [1:0]  w_crcBe;
  logic        w_crcClear;

  assign w_rxCrc    = r_odd ? {word_data[7:0], r_crcLsb} : word_data;
  assign w_crcClear = (r_state == IDLE);
  assign w_crcBe    = (r_state == PAYLOAD && word_vld && !invalid_start) ?
                      ((r_rem == 16'd1) ? 2'b01 : 2'b11) : 2'b00;

  csi2_crc16 u_crc16 (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (w_crcClear),
    .i_data  (word_data),
    .i_be    (w_crcBe),
    .o_crc   (w_crc)
  );
`else
  assign err_crc = 1'b0;
`endif

  // DONE is visited twice after a short/oversize header so packet_done lands two cycles after word1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_word0     <= '0;
      r_rem       <= '0;
      packet_done <= 1'b0;
      hdr_vld     <= 1'b0;
      vc          <= '0;
      dt          <= '0;
      wc          <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      pix_data    <= '0;
      pix_be      <= '0;
      pix_vld     <= 1'b0;
      pix_last    <= 1'b0;
      err_wc      <= 1'b0;
      err_sync    <= 1'b0;
      err_trunc   <= 1'b0;
`ifdef CSI2_CRC_CHECK_EN
      r_odd       <= 1'b0;
      r_crcLsb    <= '0;
      err_crc     <= 1'b0;
`endif
    end else begin
      packet_done <= 1'b0;
      hdr_vld     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      pix_be      <= 2'b00;
      pix_vld     <= 1'b0;
      pix_last    <= 1'b0;
      err_wc      <= 1'b0;
      err_sync    <= 1'b0;
      err_trunc   <= 1'b0;
`ifdef CSI2_CRC_CHECK_EN
      err_crc     <= 1'b0;
`endif
      if (invalid_start) begin
        err_sync <= 1'b1;
        r_state  <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (word_vld) begin
              r_word0 <= word_data;
              r_state <= HDR1;
            end
          end
          HDR1: begin
            if (!word_vld) begin
              err_trunc <= 1'b1;
              r_state   <= IDLE;
            end else begin
              vc      <= w_di[7:6];
              dt      <= w_di[5:0];
              wc      <= w_wc;
              hdr_vld <= 1'b1;
              r_rem   <= w_wc;
`ifdef CSI2_CRC_CHECK_EN
              r_odd   <= w_wc[0];
`endif
              if (w_di[5:0] <= DT_SHORT_MAX) begin
                frame_start <= (w_di[5:0] == DT_FS);
                frame_end   <= (w_di[5:0] == DT_FE);
                line_start  <= (w_di[5:0] == DT_LS);
                line_end    <= (w_di[5:0] == DT_LE);
                r_state     <= DONE;
              end else if (w_wc > MAX_WC) begin
                err_wc  <= 1'b1;
                r_state <= DONE;
              end else if (w_wc == 16'd0) begin
                r_state <= CRC;
              end else begin
                r_state <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (!word_vld) begin
              err_trunc <= 1'b1;
              r_state   <= IDLE;
            end else begin
              pix_vld  <= 1'b1;
              pix_data <= word_data;
              if (r_rem > 16'd2) begin
                pix_be <= 2'b11;
                r_rem  <= r_rem - 16'd2;
              end else if (r_rem == 16'd2) begin
                pix_be   <= 2'b11;
                pix_last <= 1'b1;
                r_state  <= CRC;
              end else begin
                pix_be   <= 2'b01;
                pix_last <= 1'b1;
`ifdef CSI2_CRC_CHECK_EN
                r_crcLsb <= word_data[15:8];
`endif
                r_state  <= CRC;
              end
            end
          end
          CRC: begin
            if (!word_vld) begin
              err_trunc <= 1'b1;
              r_state   <= IDLE;
            end else begin
              packet_done <= 1'b1;
`ifdef CSI2_CRC_CHECK_EN
              err_crc     <= (w_rxCrc != w_crc);
`endif
              r_state     <= DONE;
            end
          end
          DONE: begin
            if (packet_done) begin
              r_state <= IDLE;
            end else begin
              packet_done <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Directed self-checking bench for csi2_packet_parser; expected values are hand-computed.
// Define CSI2_CRC_CHECK_EN for both bench and RTL to exercise the CRC check.
module tb_csi2_packet_parser;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] word_data;
  logic        word_vld;
  logic        invalid_start;
  logic        packet_done;
  logic        hdr_vld;
  logic [1:0]  vc;
  logic [5:0]  dt;
  logic [15:0] wc;
  logic        frame_start;
  logic        frame_end;
  logic        line_start;
  logic        line_end;
  logic [15:0] pix_data;
  logic [1:0]  pix_be;
  logic        pix_vld;
  logic        pix_last;
  logic        err_wc;
  logic        err_sync;
  logic        err_trunc;
  logic        err_crc;

  int total = 0;
  int bad   = 0;

  logic [15:0] longPay [3];
  logic [15:0] crcWord;
  logic        expCrcErr;
  logic [3:0]  expStrobe;

  always #5 clk = ~clk;

  csi2_packet_parser dut (
    .clk           (clk),
    .resetn        (resetn),
    .word_data     (word_data),
    .word_vld      (word_vld),
    .invalid_start (invalid_start),
    .packet_done   (packet_done),
    .hdr_vld       (hdr_vld),
    .vc            (vc),
    .dt            (dt),
    .wc            (wc),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .line_start    (line_start),
    .line_end      (line_end),
    .pix_data      (pix_data),
    .pix_be        (pix_be),
    .pix_vld       (pix_vld),
    .pix_last      (pix_last),
    .err_wc        (err_wc),
    .err_sync      (err_sync),
    .err_trunc     (err_trunc),
    .err_crc       (err_crc)
  );

  // Bit-serial reference CRC step, reflected 0x1021.
  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r  = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one word, then sample just after the rising edge that consumed it.
  task automatic applyStimulus(input logic [15:0] data, input logic vld, input logic inv);
    word_data     = data;
    word_vld      = vld;
    invalid_start = inv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn        = 1'b0;
    word_data     = 16'h0000;
    word_vld      = 1'b0;
    invalid_start = 1'b0;
    longPay[0]    = 16'hA1A0;
    longPay[1]    = 16'hB1B0;
    longPay[2]    = 16'hC1C0;

    // Reset state
    applyStimulus(16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("rst_done", {31'd0, packet_done}, 32'd0);
    checkOutput("rst_hdr", {31'd0, hdr_vld}, 32'd0);
    checkOutput("rst_vcdtwc", {8'd0, vc, dt, wc}, 32'd0);
    checkOutput("rst_pix", {13'd0, pix_vld, pix_last, pix_be, pix_data}, 32'd0);
    checkOutput("rst_err", {28'd0, err_wc, err_sync, err_trunc, err_crc}, 32'd0);
    resetn = 1'b1;

    // Short FS on vc=1
    applyStimulus(16'h0040, 1'b1, 1'b0);
    checkOutput("fs_hdr_early", {31'd0, hdr_vld}, 32'd0);
    applyStimulus(16'h1500, 1'b1, 1'b0);
    checkOutput("fs_hdr", {31'd0, hdr_vld}, 32'd1);
    checkOutput("fs_vc", {30'd0, vc}, 32'd1);
    checkOutput("fs_dt", {26'd0, dt}, 32'd0);
    checkOutput("fs_wc", {16'd0, wc}, 32'd0);
    checkOutput("fs_strobes", {28'd0, frame_start, frame_end, line_start, line_end}, 32'b1000);
    checkOutput("fs_done_early", {31'd0, packet_done}, 32'd0);
    applyStimulus(16'h1500, 1'b1, 1'b0);
    checkOutput("fs_done", {31'd0, packet_done}, 32'd1);
    checkOutput("fs_strobe_gone", {31'd0, frame_start}, 32'd0);
    checkOutput("fs_nopix", {31'd0, pix_vld}, 32'd0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("fs_done_gone", {31'd0, packet_done}, 32'd0);

    // LS and LE strobes
    for (int d = 2; d < 4; d++) begin
      applyStimulus({8'h00, 8'(d)}, 1'b1, 1'b0);
      applyStimulus(16'h0000, 1'b1, 1'b0);
      expStrobe = 4'b1000 >> d;
      checkOutput("ls_le_strobe", {28'd0, frame_start, frame_end, line_start, line_end}, {28'd0, expStrobe});
      applyStimulus(16'h0000, 1'b1, 1'b0);
      checkOutput("ls_le_done", {31'd0, packet_done}, 32'd1);
      applyStimulus(16'h0000, 1'b0, 1'b0);
    end

    // Long packet dt=0x2B wc=6
    applyStimulus(16'h062B, 1'b1, 1'b0);
    applyStimulus(16'h1200, 1'b1, 1'b0);
    checkOutput("l6_hdr", {31'd0, hdr_vld}, 32'd1);
    checkOutput("l6_dt", {26'd0, dt}, 32'h2B);
    checkOutput("l6_wc", {16'd0, wc}, 32'd6);
    checkOutput("l6_nostrobe", {28'd0, frame_start, frame_end, line_start, line_end}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(longPay[i], 1'b1, 1'b0);
      checkOutput("l6_pix", {13'd0, pix_vld, pix_last, pix_be, pix_data},
                  {13'd0, 1'b1, (i == 2), 2'b11, longPay[i]});
    end
`ifdef CSI2_CRC_CHECK_EN
    crcWord = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      crcWord = crcStep(crcWord, longPay[i][7:0]);
      crcWord = crcStep(crcWord, longPay[i][15:8]);
    end
`else
    crcWord = 16'h1234;
`endif
    applyStimulus(crcWord, 1'b1, 1'b0);
    checkOutput("l6_done", {31'd0, packet_done}, 32'd1);
    checkOutput("l6_crcok", {31'd0, err_crc}, 32'd0);
    checkOutput("l6_pix_end", {31'd0, pix_vld}, 32'd0);
    applyStimulus(crcWord, 1'b1, 1'b0);
    checkOutput("l6_done_gone", {31'd0, packet_done}, 32'd0);
    applyStimulus(16'h0000, 1'b0, 1'b0);

    // Odd wc=5: last word carries CRC low byte
    applyStimulus(16'h052A, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("o5_wc", {16'd0, wc}, 32'd5);
    applyStimulus(16'h0201, 1'b1, 1'b0);
    checkOutput("o5_pix0", {13'd0, pix_vld, pix_last, pix_be, pix_data}, {13'd0, 1'b1, 1'b0, 2'b11, 16'h0201});
    applyStimulus(16'h0403, 1'b1, 1'b0);
    checkOutput("o5_pix1", {13'd0, pix_vld, pix_last, pix_be, pix_data}, {13'd0, 1'b1, 1'b0, 2'b11, 16'h0403});
    applyStimulus(16'hCC05, 1'b1, 1'b0);
    checkOutput("o5_pix2", {13'd0, pix_vld, pix_last, pix_be, pix_data}, {13'd0, 1'b1, 1'b1, 2'b01, 16'hCC05});
    applyStimulus(16'h00DD, 1'b1, 1'b0);
    checkOutput("o5_done", {31'd0, packet_done}, 32'd1);
`ifdef CSI2_CRC_CHECK_EN
    crcWord = 16'hFFFF;
    for (int b = 1; b <= 5; b++) crcWord = crcStep(crcWord, 8'(b));
    expCrcErr = (crcWord != 16'hDDCC);
`else
    expCrcErr = 1'b0;
`endif
    checkOutput("o5_crc", {31'd0, err_crc}, {31'd0, expCrcErr});
    applyStimulus(16'h00DD, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0);

    // Oversize wc=0xFFFF
    applyStimulus(16'hFF2B, 1'b1, 1'b0);
    applyStimulus(16'h00FF, 1'b1, 1'b0);
    checkOutput("big_errwc", {31'd0, err_wc}, 32'd1);
    checkOutput("big_wc", {16'd0, wc}, 32'hFFFF);
    checkOutput("big_done_early", {31'd0, packet_done}, 32'd0);
    applyStimulus(16'h00FF, 1'b1, 1'b0);
    checkOutput("big_done", {31'd0, packet_done}, 32'd1);
    checkOutput("big_nopix", {31'd0, pix_vld}, 32'd0);
    applyStimulus(16'h0000, 1'b0, 1'b0);

    // wc == MAX_WC is legal; then truncate
    applyStimulus(16'h002B, 1'b1, 1'b0);
    applyStimulus(16'h0020, 1'b1, 1'b0);
    checkOutput("max_errwc", {31'd0, err_wc}, 32'd0);
    checkOutput("max_wc", {16'd0, wc}, 32'h2000);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("max_trunc", {31'd0, err_trunc}, 32'd1);

    // wc == MAX_WC+1 is an error
    applyStimulus(16'h012B, 1'b1, 1'b0);
    applyStimulus(16'h0020, 1'b1, 1'b0);
    checkOutput("max1_errwc", {31'd0, err_wc}, 32'd1);
    applyStimulus(16'h0020, 1'b1, 1'b0);
    checkOutput("max1_done", {31'd0, packet_done}, 32'd1);
    applyStimulus(16'h0000, 1'b0, 1'b0);

    // Truncation after one payload word, then prove IDLE with a short FE
    applyStimulus(16'h062B, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h5555, 1'b1, 1'b0);
    checkOutput("tr_pix", {31'd0, pix_vld}, 32'd1);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("tr_err", {31'd0, err_trunc}, 32'd1);
    checkOutput("tr_nodone", {31'd0, packet_done}, 32'd0);
    applyStimulus(16'h0001, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("tr_fe", {28'd0, frame_start, frame_end, line_start, line_end}, 32'b0100);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("tr_fe_done", {31'd0, packet_done}, 32'd1);
    applyStimulus(16'h0000, 1'b0, 1'b0);

    // Reserved short dt: header only
    applyStimulus(16'h0005, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("rsv_hdr", {25'd0, hdr_vld, dt}, {25'd0, 1'b1, 6'h05});
    checkOutput("rsv_nostrobe", {28'd0, frame_start, frame_end, line_start, line_end}, 32'd0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("rsv_done", {31'd0, packet_done}, 32'd1);
    applyStimulus(16'h0000, 1'b0, 1'b0);

    // Long wc=0 goes straight to the trailer
    applyStimulus(16'h002B, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("z_hdr", {31'd0, hdr_vld}, 32'd1);
    applyStimulus(16'hFFFF, 1'b1, 1'b0);
    checkOutput("z_done", {31'd0, packet_done}, 32'd1);
    checkOutput("z_nopix", {31'd0, pix_vld}, 32'd0);
    checkOutput("z_crc", {31'd0, err_crc}, 32'd0);
    applyStimulus(16'hFFFF, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0);

    // invalid_start aborts the header
    applyStimulus(16'h0040, 1'b1, 1'b0);
    applyStimulus(16'h1500, 1'b1, 1'b1);
    checkOutput("is_sync", {31'd0, err_sync}, 32'd1);
    checkOutput("is_nohdr", {31'd0, hdr_vld}, 32'd0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("is_sync_gone", {31'd0, err_sync}, 32'd0);

    // Reset mid-payload
    applyStimulus(16'h062B, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h1111, 1'b1, 1'b0);
    checkOutput("mr_pix", {31'd0, pix_vld}, 32'd1);
    resetn = 1'b0;
    applyStimulus(16'h2222, 1'b1, 1'b0);
    checkOutput("mr_pix_clr", {13'd0, pix_vld, pix_last, pix_be, pix_data}, 32'd0);
    checkOutput("mr_vcdtwc", {8'd0, vc, dt, wc}, 32'd0);
    checkOutput("mr_flags", {26'd0, packet_done, hdr_vld, err_wc, err_sync, err_trunc, err_crc}, 32'd0);
    resetn = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("mr_nodone", {30'd0, packet_done, err_trunc}, 32'd0);

`ifdef CSI2_CRC_CHECK_EN
    // Corrupted trailer on wc=2
    applyStimulus(16'h022B, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h0201, 1'b1, 1'b0);
    checkOutput("ce_pix", {13'd0, pix_vld, pix_last, pix_be, pix_data}, {13'd0, 1'b1, 1'b1, 2'b11, 16'h0201});
    crcWord = crcStep(crcStep(16'hFFFF, 8'h01), 8'h02) ^ 16'h0001;
    applyStimulus(crcWord, 1'b1, 1'b0);
    checkOutput("ce_err", {30'd0, packet_done, err_crc}, 32'b11);
    applyStimulus(crcWord, 1'b1, 1'b0);
    checkOutput("ce_err_gone", {31'd0, err_crc}, 32'd0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
